// File: rtl/display_timing.sv
// Display raster timing generator.
// A clock divider produces one pix_tick per pixel; the horizontal and
// vertical counters advance on pix_tick. Sync, video_on and vblank_start
// are registered from the counters' next values so they change on the same
// clk edge as pixel_column / pixel_row. The bot location/info inputs are
// captured once per frame, at the start of vertical blanking, so the icon
// stage sees values that stay constant while a frame is drawn.
module display_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PIX_DIV  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  LocX_in,
    input  logic [7:0]  LocY_in,
    input  logic [7:0]  BotInfo_in,
    output logic        pix_tick,
    output logic [11:0] pixel_column,
    output logic [11:0] pixel_row,
    output logic        horiz_sync,
    output logic        vert_sync,
    output logic        video_on,
    output logic        vblank_start,
    output logic [7:0]  LocX_reg,
    output logic [7:0]  LocY_reg,
    output logic [7:0]  BotInfo_reg
);

    localparam logic [11:0] H_LAST   = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [11:0] V_LAST   = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [11:0] H_VIS    = 12'(H_ACTIVE);
    localparam logic [11:0] V_VIS    = 12'(V_ACTIVE);
    localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [3:0]  DIV_MAX  = 4'(PIX_DIV - 1);

    logic [3:0]  r_div;
    logic [11:0] r_col;
    logic [11:0] r_row;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_video;
    logic        r_vblank;
    logic [7:0]  r_loc_x;
    logic [7:0]  r_loc_y;
    logic [7:0]  r_bot_info;

    logic        w_tick;
    logic [11:0] w_col_next;
    logic [11:0] w_row_next;
    logic        w_vblank_next;

    // With PIX_DIV=1 the divider sits at its terminal value permanently, so
    // the pulse is gated with reset_n to keep it low while reset is held.
    assign w_tick   = (r_div == DIV_MAX);
    assign pix_tick = w_tick & reset_n;

    // Pixel clock divider: counts 0..PIX_DIV-1 and wraps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div <= 4'd0;
        end else if (w_tick) begin
            r_div <= 4'd0;
        end else begin
            r_div <= r_div + 4'd1;
        end
    end

    // Next raster position; equal to the current one when no tick is due.
    always_comb begin
        w_col_next = r_col;
        w_row_next = r_row;
        if (w_tick) begin
            if (r_col == H_LAST) begin
                w_col_next = 12'd0;
                w_row_next = (r_row == V_LAST) ? 12'd0 : r_row + 12'd1;
            end else begin
                w_col_next = r_col + 12'd1;
            end
        end
    end

    assign w_vblank_next = w_tick && (w_col_next == 12'd0) && (w_row_next == V_VIS);

    // Position counters and the flags decoded from their next values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_col    <= 12'd0;
            r_row    <= 12'd0;
            r_hsync  <= 1'b1;
            r_vsync  <= 1'b1;
            r_video  <= 1'b1;
            r_vblank <= 1'b0;
        end else begin
            r_col    <= w_col_next;
            r_row    <= w_row_next;
            r_hsync  <= !((w_col_next >= HS_START) && (w_col_next < HS_END));
            r_vsync  <= !((w_row_next >= VS_START) && (w_row_next < VS_END));
            r_video  <= (w_col_next < H_VIS) && (w_row_next < V_VIS);
            r_vblank <= w_vblank_next;
        end
    end

    // Frame-stable snapshot of the bot inputs, loaded only as blanking begins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_loc_x    <= 8'h00;
            r_loc_y    <= 8'h00;
            r_bot_info <= 8'h00;
        end else if (w_vblank_next) begin
            r_loc_x    <= LocX_in;
            r_loc_y    <= LocY_in;
            r_bot_info <= BotInfo_in;
        end
    end

    assign pixel_column = r_col;
    assign pixel_row    = r_row;
    assign horiz_sync   = r_hsync;
    assign vert_sync    = r_vsync;
    assign video_on     = r_video;
    assign vblank_start = r_vblank;
    assign LocX_reg     = r_loc_x;
    assign LocY_reg     = r_loc_y;
    assign BotInfo_reg  = r_bot_info;

endmodule

// File: doc/display_timing.md
DISPLAY_TIMING -- requirements
Module: display_timing

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameter H_FP, 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, 96, horizontal sync width in pixels.
REQ-004 Parameter H_BP, 48, horizontal back porch in pixels; H_TOTAL = sum of the four horizontal parameters = 800.
REQ-005 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-006 Parameter V_FP, 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, 2, vertical sync width in lines.
REQ-008 Parameter V_BP, 33, vertical back porch in lines; V_TOTAL = sum of the four vertical parameters = 525.
REQ-009 Parameter PIX_DIV, 4, clk cycles per pixel; legal range 1..16.
REQ-010 Port clk, input, 1, single system clock; all state is clocked on its rising edge.
REQ-011 Port reset_n, input, 1, reset that is asynchronous and active-low.
REQ-012 Port LocX_in, input, 8, bot X location from the bot register block.
REQ-013 Port LocY_in, input, 8, bot Y location from the bot register block.
REQ-014 Port BotInfo_in, input, 8, bot orientation and movement info.
REQ-015 Port pix_tick, output, 1, one-clk pulse marking each pixel advance.
REQ-016 Port pixel_column, output, 12, current horizontal count, 0..H_TOTAL-1.
REQ-017 Port pixel_row, output, 12, current vertical count, 0..V_TOTAL-1.
REQ-018 Port horiz_sync, output, 1, horizontal sync, active-low.
REQ-019 Port vert_sync, output, 1, vertical sync, active-low.
REQ-020 Port video_on, output, 1, high while the current (column, row) is inside the visible area.
REQ-021 Port vblank_start, output, 1, one-clk pulse at the start of vertical blanking.
REQ-022 Port LocX_reg, LocY_reg, BotInfo_reg, output, 8 each, frame-stable snapshots that feed the icon stage.

Function
REQ-023 Divider: a counter runs 0..PIX_DIV-1 and wraps; pix_tick SHALL be high for exactly the clk cycle in which the divider equals PIX_DIV-1.
REQ-024 Horizontal counter: on each pix_tick, it SHALL increment, and it SHALL wrap from H_TOTAL-1 to 0.
REQ-025 Vertical counter: it SHALL increment only on a pix_tick where the horizontal count is H_TOTAL-1, and it SHALL wrap from V_TOTAL-1 to 0 on that same tick.
REQ-026 pixel_column and pixel_row SHALL be the counter registers themselves, with no extra latency, and they SHALL hold steady between pix_ticks.
REQ-027 The sync, video_on and vblank_start outputs SHALL be registered and SHALL change on the same clk edge as the counters that define them; zero skew against pixel_column and pixel_row is required.
REQ-028 horiz_sync SHALL be 0 iff H_ACTIVE+H_FP <= column < H_ACTIVE+H_FP+H_SYNC, which is columns 656..751.
REQ-029 vert_sync SHALL be 0 iff V_ACTIVE+V_FP <= row < V_ACTIVE+V_FP+V_SYNC, which is rows 490..491.
REQ-030 video_on SHALL be 1 iff column < H_ACTIVE and row < V_ACTIVE.
REQ-031 vblank_start SHALL be high for exactly one clk, on the edge where the counters become (0, V_ACTIVE).
REQ-032 Snapshot: on that same edge, LocX_reg, LocY_reg and BotInfo_reg SHALL load LocX_in, LocY_in and BotInfo_in, and they SHALL hold at all other times.
REQ-033 Input changes that occur outside the snapshot edge SHALL never appear on the *_reg outputs before the next vblank_start.
REQ-034 Counter widths are 12 bits and arithmetic is unsigned; counter values SHALL never exceed TOTAL-1, so no overflow path exists.

Reset
REQ-035 While reset_n=0, asynchronously and without waiting for clk, the module SHALL force:
- divider=0 and pix_tick=0
- pixel_column=0 and pixel_row=0
- horiz_sync=1 and vert_sync=1
- video_on=1, which is consistent with position (0,0)
- vblank_start=0
- LocX_reg, LocY_reg and BotInfo_reg = 0x00
REQ-036 Reset asserted mid-frame or mid-sync SHALL abort the frame immediately, and sync SHALL go inactive in the same cycle.
REQ-037 After reset_n rises, the first pix_tick SHALL occur on the PIX_DIV-th clk edge, and counting SHALL resume from (0,0).

Verification
REQ-038 Line timing: PIX_DIV=4, free run -> each line lasts 3200 clk; horiz_sync goes low at clk 2624 of the line and stays low for 384 clk.
REQ-039 Frame timing: free run -> each frame lasts 1,680,000 clk; vert_sync is low for 6400 clk starting at row 490, column 0; video_on is high for exactly 307,200 pixel ticks per frame.
REQ-040 Snapshot: LocX_in=0x12 at vblank_start, then 0x34 mid-frame -> LocX_reg=0x12 until the next vblank_start, then 0x34.
REQ-041 Wrap: counters at (799,524) followed by one pix_tick -> (0,0), video_on=1, and vblank_start stays 0.
REQ-042 Reset mid-sync: reset_n driven to 0 at column 700, row 490 between clk edges -> horiz_sync=1, vert_sync=1 and counters=(0,0) before the next edge; counting restarts correctly after release.
REQ-043 PIX_DIV=1: pix_tick is constantly high and a line lasts 800 clk.
